// File: rtl/seg7_pkg.sv
// Shared types and pure functions for the multiplexed 7-segment display controller:
// hex-to-segment decode and leading-zero blank mask.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK  = 7'h7F;
    localparam int   MAX_DIGITS = 16;

    // Active-low {A,B,C,D,E,F,G} pattern for one hex nibble.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Walks from the top digit down; disabled digits are skipped without ending
    // the run of leading zeros, and digit 0 always stays visible.
    function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
        input logic [4*MAX_DIGITS-1:0] value,
        input logic [MAX_DIGITS-1:0]   en,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  scanning;
        mask     = '0;
        scanning = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits && en[i] && scanning) begin
                if (value[4*i +: 4] == 4'h0) begin
                    mask[i] = 1'b1;
                end else begin
                    scanning = 1'b0;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit-slot prescaler and digit index for the scan controller, plus the frame
// boundary strobe and the PWM on-window compare for the current slot.
module seg7_scan_timer #(
    parameter int  NUM_DIGITS  = 8,
    parameter int  REFRESH_DIV = 6250,
    parameter int  BRIGHT_BITS = 4,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [IDX_W-1:0]       index,
    output logic                   frame_bnd,
    output logic                   pwm_on
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int STEP  = REFRESH_DIV >> BRIGHT_BITS;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] STEP_C   = PRE_W'(STEP);

    if (REFRESH_DIV < (1 << BRIGHT_BITS)) begin : g_bad_div
        $error("seg7_scan_timer: REFRESH_DIV must be at least 2**BRIGHT_BITS");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("seg7_scan_timer: NUM_DIGITS must be in 1..16");
    end

    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] on_thresh;
    logic             tc;

    assign tc        = (prescaler == PRE_LAST);
    assign frame_bnd = tc && (index == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            index     <= '0;
        end else if (tc) begin
            prescaler <= '0;
            index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Full-scale brightness bypasses the compare so the digit never blinks off.
    assign on_thresh = PRE_W'(brightness) * STEP_C;
    assign pwm_on    = (&brightness) || (prescaler < on_thresh);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment controller: staged/shadowed display settings swapped at
// frame boundaries, leading-zero blanking, PWM brightness, registered pin drive.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 6250,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic [BRIGHT_BITS-1:0]  i_brightness,
    input  logic                    i_lz_blank,
    input  logic                    i_load,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic                    o_frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] stg_value, shd_value, nxt_value;
    logic [NUM_DIGITS-1:0]   stg_dp, shd_dp, nxt_dp;
    logic [NUM_DIGITS-1:0]   stg_en, shd_en, nxt_en;
    logic [BRIGHT_BITS-1:0]  stg_bright, shd_bright, nxt_bright;
    logic                    stg_lz, nxt_lz;
    logic                    pending, nxt_pending;
    logic [NUM_DIGITS-1:0]   blank_q, new_blank;

    logic [IDX_W-1:0]        index;
    logic                    frame_bnd;
    logic                    pwm_on;
    logic                    commit;
    logic                    frame_p0;

    seg7_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BRIGHT_BITS (BRIGHT_BITS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .brightness (shd_bright),
        .index      (index),
        .frame_bnd  (frame_bnd),
        .pwm_on     (pwm_on)
    );

    // A load landing on the boundary cycle is folded in before the swap, so it
    // still reaches the display in the very next frame.
    assign nxt_value   = i_load ? i_value      : stg_value;
    assign nxt_dp      = i_load ? i_dp         : stg_dp;
    assign nxt_en      = i_load ? i_digit_en   : stg_en;
    assign nxt_bright  = i_load ? i_brightness : stg_bright;
    assign nxt_lz      = i_load ? i_lz_blank   : stg_lz;
    assign nxt_pending = i_load | pending;
    assign commit      = frame_bnd & nxt_pending;

    logic [4*MAX_DIGITS-1:0] value_wide;
    logic [MAX_DIGITS-1:0]   en_wide;
    logic [MAX_DIGITS-1:0]   mask_wide;

    always_comb begin
        value_wide                   = '0;
        value_wide[4*NUM_DIGITS-1:0] = nxt_value;
        en_wide                      = '0;
        en_wide[NUM_DIGITS-1:0]      = nxt_en;
        mask_wide                    = nxt_lz ? lz_blank_mask(value_wide, en_wide, NUM_DIGITS) : '0;
        new_blank                    = mask_wide[NUM_DIGITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_value  <= '0;
            stg_dp     <= '0;
            stg_en     <= '0;
            stg_bright <= '0;
            stg_lz     <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (i_load) begin
                stg_value  <= i_value;
                stg_dp     <= i_dp;
                stg_en     <= i_digit_en;
                stg_bright <= i_brightness;
                stg_lz     <= i_lz_blank;
            end
            pending <= commit ? 1'b0 : nxt_pending;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_value  <= '0;
            shd_dp     <= '0;
            shd_en     <= '0;
            shd_bright <= '0;
            blank_q    <= '0;
        end else if (commit) begin
            shd_value  <= nxt_value;
            shd_dp     <= nxt_dp;
            shd_en     <= nxt_en;
            shd_bright <= nxt_bright;
            blank_q    <= new_blank;
        end
    end

    logic [3:0]            cur_nib;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_nxt;
    seg_t                  seg_nxt;
    logic                  dp_nxt;

    always_comb begin
        cur_nib = shd_value[4*index +: 4];
        lit     = shd_en[index] & pwm_on;
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        if (lit) begin
            an_nxt  = ~(NUM_DIGITS'(1) << index);
            seg_nxt = blank_q[index] ? SEG_BLANK : hex_to_seg(cur_nib);
            dp_nxt  = ~shd_dp[index];
        end
    end

    // Pin drive stage: one cycle behind the timer state; o_frame is delayed to match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_p0 <= 1'b0;
            o_frame  <= 1'b0;
            o_an     <= '1;
            o_seg    <= SEG_BLANK;
            o_dp     <= 1'b1;
        end else begin
            frame_p0 <= frame_bnd;
            o_frame  <= frame_p0;
            o_an     <= an_nxt;
            o_seg    <= seg_nxt;
            o_dp     <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (4 digits, 16-cycle slots, 2-bit brightness) against a
// cycle-count reference model of the display behaviour.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic [3:0]  i_digit_en;
    logic [1:0]  i_brightness;
    logic        i_lz_blank;
    logic        i_load;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame;

    int n_cmp  = 0;
    int n_fail = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (16),
        .BRIGHT_BITS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_value      (i_value),
        .i_dp         (i_dp),
        .i_digit_en   (i_digit_en),
        .i_brightness (i_brightness),
        .i_lz_blank   (i_lz_blank),
        .i_load       (i_load),
        .o_an         (o_an),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_frame      (o_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [12:0] RST_VEC = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [1:0]  br;
        logic        lz;
    } disp_t;

    disp_t       in_now, m_stg, m_shd;
    logic        m_pend;
    int unsigned m_cyc;
    logic [12:0] exp_vec;
    logic [12:0] obs;

    assign in_now = {i_value, i_dp, i_digit_en, i_brightness, i_lz_blank};
    assign obs    = {o_an, o_seg, o_dp, o_frame};

    // Expected pins after the edge that consumed scan position t (t = cycles since reset).
    function automatic logic [12:0] expect_out(input int unsigned t, input disp_t s);
        int unsigned p, d;
        logic        lit, blanked, frame;
        logic [3:0]  an;
        logic [6:0]  seg;
        p     = t % 16;
        d     = (t / 16) % 4;
        frame = (t % 64 == 0) && (t >= 64);
        lit   = s.en[d] && (s.br == 2'd3 || p < s.br * 4);
        blanked = s.lz && (d != 0);
        for (int j = d; j < 4; j++) begin
            if (s.en[j] && s.v[4*j +: 4] != 4'h0) blanked = 1'b0;
        end
        if (!lit) return {4'hF, 7'h7F, 1'b1, frame};
        an    = 4'hF;
        an[d] = 1'b0;
        seg   = blanked ? 7'h7F : hex_tab[s.v[4*d +: 4]];
        return {an, seg, ~s.dp[d], frame};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc   <= 0;
            m_stg   <= '0;
            m_shd   <= '0;
            m_pend  <= 1'b0;
            exp_vec <= RST_VEC;
        end else begin
            exp_vec <= expect_out(m_cyc, m_shd);
            m_stg   <= i_load ? in_now : m_stg;
            if ((m_cyc % 64 == 63) && (m_pend || i_load)) begin
                m_shd  <= i_load ? in_now : m_stg;
                m_pend <= 1'b0;
            end else begin
                m_pend <= m_pend | i_load;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                           input logic [1:0] br, input logic lz);
        i_value      = v;
        i_dp         = dp;
        i_digit_en   = en;
        i_brightness = br;
        i_lz_blank   = lz;
        i_load       = 1'b1;
        @(negedge clk);
        i_load       = 1'b0;
    endtask

    task automatic wait_frame(output bit timed_out);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_frame && k < 200);
        timed_out = !o_frame;
    endtask

    task automatic test_reset;
        int pulses = 0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want %h", obs, RST_VEC);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 194; i++) begin
            @(negedge clk);
            if (o_frame) pulses++;
            n_cmp++;
            if (obs !== exp_vec || o_an !== 4'hF) begin
                n_fail++;
                $display("FAIL reset_dark cyc%0d: got %h want %h", i, obs, exp_vec);
            end
        end
        n_cmp++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL reset_frames: got %0d pulses want 3", pulses);
        end
    endtask

    task automatic test_display;
        bit to1, to2;
        do_load(16'h12AF, 4'b0010, 4'hF, 2'd3, 1'b0);
        wait_frame(to1);
        wait_frame(to2);
        n_cmp++;
        if (to1 || to2) begin
            n_fail++;
            $display("FAIL display_frame_timeout: got no o_frame want pulse");
        end
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL display_model i%0d: got %h want %h", i, obs, exp_vec);
            end
            if (i < 16) begin
                n_cmp++;
                if (o_an !== 4'b1110 || o_seg !== 7'b0111000 || o_dp !== 1'b1) begin
                    n_fail++;
                    $display("FAIL display_d0 i%0d: got %b/%b/%b want 1110/0111000/1", i, o_an, o_seg, o_dp);
                end
            end
            if (i == 16) begin
                n_cmp++;
                if (o_an !== 4'b1101 || o_seg !== 7'b0001000 || o_dp !== 1'b0) begin
                    n_fail++;
                    $display("FAIL display_d1: got %b/%b/%b want 1101/0001000/0", o_an, o_seg, o_dp);
                end
            end
            if (i == 48) begin
                n_cmp++;
                if (o_an !== 4'b0111 || o_seg !== 7'b1001111) begin
                    n_fail++;
                    $display("FAIL display_d3: got %b/%b want 0111/1001111", o_an, o_seg);
                end
            end
        end
    endtask

    task automatic test_brightness;
        bit to1, to2;
        logic [3:0] want_an;
        for (int b = 1; b >= 0; b--) begin
            do_load(16'h12AF, 4'b0010, 4'hF, 2'(b), 1'b0);
            wait_frame(to1);
            wait_frame(to2);
            n_cmp++;
            if (to1 || to2) begin
                n_fail++;
                $display("FAIL bright_frame_timeout: got no o_frame want pulse");
            end
            for (int i = 0; i < 64; i++) begin
                if (i > 0) @(negedge clk);
                want_an = 4'hF;
                if (b == 1 && (i % 16) < 4) want_an[i / 16] = 1'b0;
                n_cmp++;
                if (o_an !== want_an || obs !== exp_vec) begin
                    n_fail++;
                    $display("FAIL bright%0d i%0d: got an=%b full=%h want an=%b full=%h",
                             b, i, o_an, obs, want_an, exp_vec);
                end
            end
        end
    endtask

    task automatic test_lz;
        bit to1, to2;
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        for (int c = 0; c < 2; c++) begin
            do_load(vals[c], 4'b0000, 4'hF, 2'd3, 1'b1);
            wait_frame(to1);
            wait_frame(to2);
            n_cmp++;
            if (to1 || to2) begin
                n_fail++;
                $display("FAIL lz_frame_timeout: got no o_frame want pulse");
            end
            for (int i = 0; i < 64; i++) begin
                if (i > 0) @(negedge clk);
                n_cmp++;
                if (obs !== exp_vec) begin
                    n_fail++;
                    $display("FAIL lz_model c%0d i%0d: got %h want %h", c, i, obs, exp_vec);
                end
                if (i % 16 == 0) begin
                    logic [6:0] want_seg;
                    want_seg = 7'h7F;
                    if (i == 0) want_seg = 7'b0000001;
                    if (i == 16 && c == 0) want_seg = 7'b0100100;
                    n_cmp++;
                    if (o_an !== ~(4'b0001 << (i / 16)) || o_seg !== want_seg) begin
                        n_fail++;
                        $display("FAIL lz_digit c%0d d%0d: got %b/%b want %b/%b",
                                 c, i / 16, o_an, o_seg, ~(4'b0001 << (i / 16)), want_seg);
                    end
                end
            end
        end
    endtask

    task automatic test_tear;
        bit to1;
        int k = 0;
        wait_frame(to1);
        for (int i = 0; i < 10; i++) @(negedge clk);
        do_load(16'h1111, 4'b0000, 4'hF, 2'd3, 1'b0);
        for (int i = 0; i < 10; i++) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'hF, 2'd3, 1'b0);
        while (!o_frame && k < 100) begin
            n_cmp++;
            if (o_seg === 7'b1001111 || obs !== exp_vec) begin
                n_fail++;
                $display("FAIL tear_before: got %h want %h", obs, exp_vec);
            end
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (to1 || !o_frame) begin
            n_fail++;
            $display("FAIL tear_frame_timeout: got no o_frame want pulse");
        end
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (o_seg !== 7'b0010010 || obs !== exp_vec) begin
                n_fail++;
                $display("FAIL tear_after i%0d: got %h want seg 0010010 full %h", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit to1, to2;
        wait_frame(to1);
        for (int i = 0; i < 62; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL b2b_model i%0d: got %h want %h", i, obs, exp_vec);
            end
        end
        do_load(16'h3456, 4'b0001, 4'hF, 2'd3, 1'b0);
        wait_frame(to2);
        n_cmp++;
        if (to1 || to2 || o_an !== 4'b1110 || o_seg !== 7'b0100000 || o_dp !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_boundary_load: got %b/%b/%b want 1110/0100000/0", o_an, o_seg, o_dp);
        end
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL b2b_after i%0d: got %h want %h", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit to1, to2;
        do_load(16'h12AF, 4'b0010, 4'hF, 2'd3, 1'b0);
        wait_frame(to1);
        wait_frame(to2);
        for (int i = 0; i < 37; i++) @(negedge clk);
        n_cmp++;
        if (to1 || to2 || o_an === 4'hF) begin
            n_fail++;
            $display("FAIL rstmid_lit: got an=%b want a lit digit", o_an);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RST_VEC) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want %h", obs, RST_VEC);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o_an !== 4'hF || obs !== exp_vec) begin
                n_fail++;
                $display("FAIL rstmid_dark i%0d: got %h want %h", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL random_model i%0d: got %h want %h", i, obs, exp_vec);
            end
            if ($urandom_range(0, 39) == 0) begin
                i_value      = 16'($urandom);
                if ($urandom_range(0, 1) == 1) i_value = i_value & 16'h00FF;
                i_dp         = 4'($urandom);
                i_digit_en   = 4'($urandom);
                i_brightness = 2'($urandom);
                i_lz_blank   = 1'($urandom);
                i_load       = 1'b1;
            end else begin
                i_load       = 1'b0;
            end
        end
        i_load = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        i_value      = '0;
        i_dp         = '0;
        i_digit_en   = '0;
        i_brightness = '0;
        i_lz_blank   = 1'b0;
        i_load       = 1'b0;
        test_reset();
        test_display();
        test_brightness();
        test_lz();
        test_tear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
